// File: rtl/dma_swchrsp_mem_responder_if.sv
// Memory-side bus between the switch-response FIFO controllers and the responder.
// Carries both clients' write/read ports plus the parity test and status signals.
interface dma_swchrsp_mem_responder_if #(
    parameter int unsigned DWIDTH = 64,
    parameter int unsigned AWIDTH = 8
);
    logic [AWIDTH-1:0] f0_waddr;
    logic [DWIDTH-1:0] f0_wdata;
    logic              f0_write;
    logic [AWIDTH-1:0] f0_raddr;
    logic [DWIDTH-1:0] f0_rdata;

    logic [AWIDTH-1:0] f1_waddr;
    logic [DWIDTH-1:0] f1_wdata;
    logic              f1_write;
    logic [AWIDTH-1:0] f1_raddr;
    logic [DWIDTH-1:0] f1_rdata;

    logic              inj_err;
    logic              clr_err;
    logic              mem_ready;
    logic [1:0]        par_err;

    modport master (
        output f0_waddr, f0_wdata, f0_write, f0_raddr,
        output f1_waddr, f1_wdata, f1_write, f1_raddr,
        output inj_err, clr_err,
        input  f0_rdata, f1_rdata, mem_ready, par_err
    );

    modport slave (
        input  f0_waddr, f0_wdata, f0_write, f0_raddr,
        input  f1_waddr, f1_wdata, f1_write, f1_raddr,
        input  inj_err, clr_err,
        output f0_rdata, f1_rdata, mem_ready, par_err
    );
endinterface

// File: rtl/dma_swchrsp_mem_responder.sv
// Two-region parity-protected storage for the switch-response FIFOs.
// Clears both regions after reset, then serves writes, zero-latency reads and sticky parity flags.
module dma_swchrsp_mem_responder #(
    parameter int unsigned DWIDTH = 64,
    parameter int unsigned AWIDTH = 8
) (
    input  logic clk,
    input  logic rst,
    dma_swchrsp_mem_responder_if.slave bus
);
    localparam int unsigned DEPTH = 1 << AWIDTH;
    localparam int unsigned WW    = DWIDTH + 1;

    typedef enum logic {
        ST_INIT,
        ST_READY
    } state_e;

    state_e            state_q, state_d;
    logic [AWIDTH-1:0] init_cnt_q, init_cnt_d;
    logic [1:0]        par_err_q, par_err_d;

    logic [WW-1:0]     mem0_q [DEPTH];
    logic [WW-1:0]     mem1_q [DEPTH];

    logic [WW-1:0]     rd0_word, rd1_word;
    logic              ready;

    assign ready    = (state_q == ST_READY);
    assign rd0_word = mem0_q[bus.f0_raddr];
    assign rd1_word = mem1_q[bus.f1_raddr];

    // State, clear counter and sticky error flags
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_INIT;
            init_cnt_q <= '0;
            par_err_q  <= '0;
        end else begin
            state_q    <= state_d;
            init_cnt_q <= init_cnt_d;
            par_err_q  <= par_err_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        init_cnt_d = init_cnt_q;
        par_err_d  = par_err_q;
        case (state_q)
            ST_INIT: begin
                init_cnt_d = init_cnt_q + AWIDTH'(1);
                if (init_cnt_q == {AWIDTH{1'b1}}) begin
                    state_d = ST_READY;
                end
            end
            ST_READY: begin
                if (bus.clr_err) begin
                    par_err_d = '0;
                end
                // A mismatch on the addressed word beats a concurrent clear
                if (^rd0_word) begin
                    par_err_d[0] = 1'b1;
                end
                if (^rd1_word) begin
                    par_err_d[1] = 1'b1;
                end
            end
            default: state_d = ST_INIT;
        endcase
    end

    // Storage: clearing sweep during init, client writes once ready
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (state_q == ST_INIT) begin
                mem0_q[init_cnt_q] <= '0;
                mem1_q[init_cnt_q] <= '0;
            end else begin
                if (bus.f0_write) begin
                    mem0_q[bus.f0_waddr] <= {(^bus.f0_wdata) ^ bus.inj_err, bus.f0_wdata};
                end
                if (bus.f1_write) begin
                    mem1_q[bus.f1_waddr] <= {(^bus.f1_wdata) ^ bus.inj_err, bus.f1_wdata};
                end
            end
        end
    end

    assign bus.f0_rdata  = ready ? rd0_word[DWIDTH-1:0] : '0;
    assign bus.f1_rdata  = ready ? rd1_word[DWIDTH-1:0] : '0;
    assign bus.mem_ready = ready;
    assign bus.par_err   = par_err_q;

endmodule

// File: tb/tb_dma_swchrsp_mem_responder.sv
// Scoreboard bench for dma_swchrsp_mem_responder: stimulus queues expected values tagged with
// the cycle they apply to; a negedge monitor pops and compares them against the DUT outputs.
module tb_dma_swchrsp_mem_responder;
    localparam int unsigned DW = 64;
    localparam int unsigned AW = 8;

    localparam int SIG_F0  = 0;
    localparam int SIG_F1  = 1;
    localparam int SIG_RDY = 2;
    localparam int SIG_PAR = 3;

    typedef struct {
        int          cyc;
        int          sig;
        logic [63:0] exp;
        string       name;
    } exp_t;

    logic clk;
    logic rst;
    int   cyc_cnt;
    int   checks;
    int   failures;
    exp_t sb_q[$];

    dma_swchrsp_mem_responder_if #(.DWIDTH(DW), .AWIDTH(AW)) bus ();

    dma_swchrsp_mem_responder #(.DWIDTH(DW), .AWIDTH(AW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc_cnt = 0;
    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    function automatic logic [63:0] sample(input int sig);
        case (sig)
            SIG_F0:  return bus.f0_rdata;
            SIG_F1:  return bus.f1_rdata;
            SIG_RDY: return 64'(bus.mem_ready);
            default: return 64'(bus.par_err);
        endcase
    endfunction

    // Monitor: every expectation due by this cycle is compared mid-cycle
    always @(negedge clk) begin
        while (sb_q.size() > 0 && sb_q[0].cyc <= cyc_cnt) begin
            exp_t e;
            logic [63:0] act;
            e = sb_q.pop_front();
            act = sample(e.sig);
            checks++;
            if (e.cyc != cyc_cnt || act !== e.exp) begin
                failures++;
                $display("FAIL %s cyc=%0d due=%0d actual=%h expected=%h",
                         e.name, cyc_cnt, e.cyc, act, e.exp);
            end
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic expect_at(input int d, input int sig, input logic [63:0] v, input string nm);
        exp_t e;
        e.cyc  = cyc_cnt + d;
        e.sig  = sig;
        e.exp  = v;
        e.name = nm;
        sb_q.push_back(e);
    endtask

    logic [AW-1:0] a;

    initial begin
        checks   = 0;
        failures = 0;
        rst = 1'b1;
        bus.f0_waddr = '0; bus.f0_wdata = '0; bus.f0_write = 1'b0; bus.f0_raddr = '0;
        bus.f1_waddr = '0; bus.f1_wdata = '0; bus.f1_write = 1'b0; bus.f1_raddr = '0;
        bus.inj_err = 1'b0; bus.clr_err = 1'b0;

        // Reset and full clear sweep
        step(3);
        rst = 1'b0;
        expect_at(0, SIG_F0, 64'h0, "init_rdata0");
        expect_at(0, SIG_PAR, 64'h0, "init_par");
        for (int k = 0; k <= 256; k++) begin
            expect_at(k, SIG_RDY, (k == 256) ? 64'h1 : 64'h0, "init_ready");
        end
        step(256);
        bus.f0_raddr = 8'h00; bus.f1_raddr = 8'hFF;
        expect_at(0, SIG_F0, 64'h0, "clr_f0_00");
        expect_at(0, SIG_F1, 64'h0, "clr_f1_ff");
        expect_at(0, SIG_PAR, 64'h0, "clr_par");
        step(1);
        bus.f0_raddr = 8'hFF; bus.f1_raddr = 8'h00;
        expect_at(0, SIG_F0, 64'h0, "clr_f0_ff");
        expect_at(0, SIG_F1, 64'h0, "clr_f1_00");
        step(1);

        // Single write, read-during-write returns old word, region isolation
        bus.f0_waddr = 8'd5; bus.f0_wdata = 64'hDEAD_BEEF_0123_4567; bus.f0_write = 1'b1;
        bus.f0_raddr = 8'd5; bus.f1_raddr = 8'd5;
        expect_at(0, SIG_F0, 64'h0, "rdw_old");
        expect_at(0, SIG_F1, 64'h0, "iso_same_cycle");
        step(1);
        bus.f0_write = 1'b0;
        expect_at(0, SIG_F0, 64'hDEAD_BEEF_0123_4567, "wr_f0_5");
        expect_at(0, SIG_F1, 64'h0, "iso_f1_5");
        step(1);

        // Simultaneous writes to the top address, then wrap to zero
        bus.f0_waddr = 8'hFF; bus.f0_wdata = 64'hAAAA_5555_0F0F_F0F0; bus.f0_write = 1'b1;
        bus.f1_waddr = 8'hFF; bus.f1_wdata = 64'h1234_5678_9ABC_DEF1; bus.f1_write = 1'b1;
        bus.f0_raddr = 8'hFF; bus.f1_raddr = 8'hFF;
        step(1);
        bus.f0_write = 1'b0; bus.f1_write = 1'b0;
        expect_at(0, SIG_F0, 64'hAAAA_5555_0F0F_F0F0, "dual_f0_ff");
        expect_at(0, SIG_F1, 64'h1234_5678_9ABC_DEF1, "dual_f1_ff");
        expect_at(0, SIG_PAR, 64'h0, "dual_par");
        step(1);
        a = 8'hFF;
        bus.f0_waddr = a; bus.f0_wdata = 64'h0000_0000_0000_00C3; bus.f0_write = 1'b1;
        step(1);
        a = a + 8'd1;
        bus.f0_waddr = a; bus.f0_wdata = 64'h0000_0000_0000_00D7;
        step(1);
        bus.f0_write = 1'b0; bus.f0_raddr = 8'h00;
        expect_at(0, SIG_F0, 64'h0000_0000_0000_00D7, "wrap_00");
        step(1);
        bus.f0_raddr = 8'hFF;
        expect_at(0, SIG_F0, 64'h0000_0000_0000_00C3, "wrap_ff");
        step(1);

        // Injected parity error on client 1, sticky flag and clear priority
        bus.f1_raddr = 8'd0;
        bus.f1_waddr = 8'd7; bus.f1_wdata = 64'h1; bus.f1_write = 1'b1; bus.inj_err = 1'b1;
        step(1);
        bus.f1_write = 1'b0; bus.inj_err = 1'b0; bus.f1_raddr = 8'd7;
        expect_at(0, SIG_PAR, 64'h0, "par_before");
        expect_at(0, SIG_F1, 64'h1, "par_data");
        expect_at(1, SIG_PAR, 64'h2, "par_set");
        step(1);
        bus.f1_raddr = 8'd0;
        expect_at(0, SIG_PAR, 64'h2, "par_sticky0");
        expect_at(1, SIG_PAR, 64'h2, "par_sticky1");
        step(1);
        bus.clr_err = 1'b1;
        expect_at(1, SIG_PAR, 64'h0, "par_clr");
        step(1);
        bus.clr_err = 1'b0;
        expect_at(0, SIG_PAR, 64'h0, "par_clr_hold");
        bus.f1_raddr = 8'd7; bus.clr_err = 1'b1;
        expect_at(1, SIG_PAR, 64'h2, "par_clr_loses");
        step(1);
        expect_at(1, SIG_PAR, 64'h2, "par_clr_loses2");
        step(1);
        bus.clr_err = 1'b0; bus.f1_raddr = 8'd0;
        step(1);

        // Mid-traffic reset, then reset mid-init; writes during init are dropped
        rst = 1'b1;
        expect_at(1, SIG_RDY, 64'h0, "rst_traffic_rdy");
        expect_at(1, SIG_PAR, 64'h0, "rst_traffic_par");
        step(1);
        rst = 1'b0;
        bus.f0_waddr = 8'd3; bus.f0_wdata = 64'h1; bus.f0_write = 1'b1; bus.f0_raddr = 8'd3;
        expect_at(0, SIG_F0, 64'h0, "init_rdata_gate");
        expect_at(100, SIG_RDY, 64'h0, "mid_init_rdy");
        step(100);
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        expect_at(0, SIG_RDY, 64'h0, "restart_rdy");
        expect_at(0, SIG_PAR, 64'h0, "restart_par");
        expect_at(255, SIG_RDY, 64'h0, "restart_rdy_255");
        expect_at(256, SIG_RDY, 64'h1, "restart_rdy_256");
        step(256);
        bus.f0_write = 1'b0;
        expect_at(0, SIG_F0, 64'h0, "init_write_dropped");
        step(1);
        bus.f0_raddr = 8'd5; bus.f1_raddr = 8'hFF;
        expect_at(0, SIG_F0, 64'h0, "restart_f0_5");
        expect_at(0, SIG_F1, 64'h0, "restart_f1_ff");
        step(1);
        bus.f1_raddr = 8'd7;
        expect_at(0, SIG_F1, 64'h0, "restart_f1_7");
        expect_at(1, SIG_PAR, 64'h0, "restart_par_7");
        step(2);

        if (sb_q.size() != 0) begin
            $display("FAIL scoreboard_drain actual=%0d pending expected=0", sb_q.size());
            failures += sb_q.size();
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
